// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential popcount block.
//   popcount_state_t : controller state encoding (IDLE, COUNT, DONE)
//   cnt_wl(wl)       : width needed to hold a count of 0..wl set bits
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } popcount_state_t;

  function automatic int unsigned cnt_wl(input int unsigned wl);
    return $clog2(wl + 1);
  endfunction

endpackage

// File: rtl/count_ones.sv
// Combinational population count of a WL-bit slice.
//   data  : slice to count
//   count : number of set bits in data, cnt_wl(WL) bits wide
module count_ones
  import popcount_pkg::*;
#(
  parameter int unsigned WL = 32
) (
  input  logic [WL-1:0]          data,
  output logic [cnt_wl(WL)-1:0]  count
);

  localparam int unsigned CW = cnt_wl(WL);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WL; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// Time-multiplexed popcount of a DATA_WL-bit word, one CHUNK_WL-bit slice per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   abort               : synchronous cancel of any word in flight or result pending
//   in_valid/in_ready   : input handshake, in_data is the word to count
//   out_valid/out_ready : result handshake, out_count is the number of set bits
//   busy                : high while slices are being counted
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int unsigned DATA_WL    = 128,
  parameter int unsigned CHUNK_WL   = 32,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         abort,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WL-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cnt_wl(DATA_WL)-1:0]   out_count,
  output logic                         busy
);

  localparam int unsigned NUM_CHUNKS = DATA_WL / CHUNK_WL;
  localparam int unsigned CW         = cnt_wl(DATA_WL);
  localparam int unsigned PW         = cnt_wl(CHUNK_WL);
  localparam int unsigned IW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if ((DATA_WL % CHUNK_WL) != 0 || CHUNK_WL == 0) begin : g_bad_cfg
    $error("popcount_seq: DATA_WL must be a non-zero multiple of CHUNK_WL");
  end

  popcount_state_t     state_q, state_d;
  logic [DATA_WL-1:0]  sreg_q, sreg_d;
  logic [CW-1:0]       acc_q, acc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       out_count_q, out_count_d;

  logic [PW-1:0]       chunk_cnt;
  logic [CW-1:0]       acc_sum;
  logic [DATA_WL-1:0]  sreg_shift;
  logic                last_chunk;
  logic                rest_zero;
  logic                load;

  count_ones #(
    .WL (CHUNK_WL)
  ) u_count_ones (
    .data  (sreg_q[CHUNK_WL-1:0]),
    .count (chunk_cnt)
  );

  assign acc_sum    = acc_q + CW'(chunk_cnt);
  assign sreg_shift = sreg_q >> CHUNK_WL;
  assign last_chunk = (idx_q == IW'(NUM_CHUNKS - 1));
  assign rest_zero  = EARLY_EXIT && (sreg_shift == '0);

  // abort and reset mask both handshakes so nothing completes on a cancelling edge
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst && !abort) begin
      unique case (state_q)
        IDLE:    in_ready = 1'b1;
        DONE:    begin
          in_ready  = out_ready;
          out_valid = 1'b1;
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign busy      = (state_q == COUNT);
  assign out_count = out_count_q;
  assign load      = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_d = COUNT;
            sreg_d  = in_data;
            acc_d   = '0;
            idx_d   = '0;
          end
        end
        COUNT: begin
          acc_d  = acc_sum;
          sreg_d = sreg_shift;
          idx_d  = idx_q + IW'(1);
          if (last_chunk || rest_zero) begin
            state_d     = DONE;
            out_count_d = acc_sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (load) begin
              state_d = COUNT;
              sreg_d  = in_data;
              acc_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq: default instance plus an EARLY_EXIT instance.
module tb_popcount_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         abort0 = 1'b0, iv0 = 1'b0, ir0, ov0, ordy0 = 1'b0, busy0;
  logic [127:0] din0 = '0;
  logic [7:0]   cnt0;
  logic         abort1 = 1'b0, iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0, busy1;
  logic [127:0] din1 = '0;
  logic [7:0]   cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  popcount_seq #(
    .DATA_WL    (128),
    .CHUNK_WL   (32),
    .EARLY_EXIT (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort0),
    .in_valid  (iv0),
    .in_ready  (ir0),
    .in_data   (din0),
    .out_valid (ov0),
    .out_ready (ordy0),
    .out_count (cnt0),
    .busy      (busy0)
  );

  popcount_seq #(
    .DATA_WL    (128),
    .CHUNK_WL   (32),
    .EARLY_EXIT (1'b1)
  ) dut_ee (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort1),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .in_data   (din1),
    .out_valid (ov1),
    .out_ready (ordy1),
    .out_count (cnt1),
    .busy      (busy1)
  );

  // Reference: set bits in the word
  function automatic int popc(input logic [127:0] d);
    return $countones(d);
  endfunction

  // Reference: early-exit latency = index of highest non-zero 32-bit chunk + 1, at least 1
  function automatic int ee_lat(input logic [127:0] d);
    int l;
    logic [127:0] s;
    l = 1;
    for (int c = 0; c < 4; c++) begin
      s = d >> (c * 32);
      if (s[31:0] != 32'd0) l = c + 1;
    end
    return l;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand_sparse();
    logic [127:0] d;
    d = '0;
    for (int c = 0; c < 4; c++) begin
      if ($urandom_range(1, 0) == 1) d = d | (128'($urandom) << (c * 32));
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one word, then counts clocks from the accepting edge until out_valid.
  task automatic send_and_measure(input bit ee, input logic [127:0] d, output int lat,
                                  output int busy_n, output logic [7:0] c);
    int guard;
    if (!ee) begin iv0 = 1'b1; din0 = d; end
    else     begin iv1 = 1'b1; din1 = d; end
    #1;
    guard = 0;
    while (!(ee ? ir1 : ir0) && guard < 50) begin step(); guard++; end
    step();
    if (!ee) iv0 = 1'b0; else iv1 = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!(ee ? ov1 : ov0) && lat < 50) begin
      if (ee ? busy1 : busy0) busy_n++;
      step();
      lat++;
    end
    c = ee ? cnt1 : cnt0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", ov0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt0); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov_ee got %b want 0", ov1); end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_ir got %b want 1", ir0); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_ir_ee got %b want 1", ir1); end
  endtask

  task automatic test_all_ones();
    int lat, bn;
    logic [7:0] c;
    ordy0 = 1'b1;
    send_and_measure(1'b0, {128{1'b1}}, lat, bn, c);
    checks++; if (lat != 4) begin errors++; $display("FAIL ones_lat got %0d want 4", lat); end
    checks++; if (bn != 4) begin errors++; $display("FAIL ones_busy got %0d want 4", bn); end
    checks++; if (c !== 8'd128) begin errors++; $display("FAIL ones_cnt got %0d want 128", c); end
    step();
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ones_drop got %b want 0", ov0); end
  endtask

  task automatic test_patterns();
    int lat, bn;
    logic [7:0] c;
    logic [127:0] w;
    ordy0 = 1'b1;
    w = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    send_and_measure(1'b0, w, lat, bn, c);
    checks++; if (c !== 8'd2) begin errors++; $display("FAIL edge_bits_cnt got %0d want 2", c); end
    checks++; if (lat != 4) begin errors++; $display("FAIL edge_bits_lat got %0d want 4", lat); end
    for (int i = 0; i < 4; i++) begin
      w = rand128();
      send_and_measure(1'b0, w, lat, bn, c);
      checks++;
      if (int'(c) != popc(w) || lat != 4) begin
        errors++;
        $display("FAIL rand_word cnt=%0d lat=%0d want cnt=%0d lat=4", c, lat, popc(w));
      end
    end
    step();
  endtask

  task automatic test_early_exit();
    int lat, bn;
    logic [7:0] c;
    logic [127:0] w;
    ordy1 = 1'b1;
    send_and_measure(1'b1, 128'h1, lat, bn, c);
    checks++;
    if (c !== 8'd1 || lat != 1) begin
      errors++; $display("FAIL ee_one cnt=%0d lat=%0d want cnt=1 lat=1", c, lat);
    end
    send_and_measure(1'b1, 128'h0, lat, bn, c);
    checks++;
    if (c !== 8'd0 || lat != 1) begin
      errors++; $display("FAIL ee_zero cnt=%0d lat=%0d want cnt=0 lat=1", c, lat);
    end
    for (int i = 0; i < 8; i++) begin
      w = rand_sparse();
      send_and_measure(1'b1, w, lat, bn, c);
      checks++;
      if (int'(c) != popc(w) || lat != ee_lat(w)) begin
        errors++;
        $display("FAIL ee_rand cnt=%0d lat=%0d want cnt=%0d lat=%0d", c, lat, popc(w), ee_lat(w));
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat, bn, l;
    logic [7:0] c;
    logic [127:0] w;
    w = rand128();
    ordy0 = 1'b0;
    send_and_measure(1'b0, w, lat, bn, c);
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_lat got %0d want 4", lat); end
    din0 = 128'hFF;
    iv0 = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ov0 !== 1'b1 || int'(cnt0) != popc(w) || ir0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold ov=%b cnt=%0d ir=%b want ov=1 cnt=%0d ir=0", ov0, cnt0, ir0, popc(w));
      end
      step();
    end
    ordy0 = 1'b1;
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", ir0); end
    step();
    iv0 = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL bp_b2b ov=%b busy=%b want ov=0 busy=1", ov0, busy0);
    end
    l = 0;
    while (!ov0 && l < 50) begin step(); l++; end
    checks++;
    if (l != 4 || cnt0 !== 8'd8) begin
      errors++; $display("FAIL bp_second lat=%0d cnt=%0d want lat=4 cnt=8", l, cnt0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] q[$];
    int sent, got, last, cyc;
    sent = 0; got = 0; last = -1; cyc = 0;
    ordy0 = 1'b1;
    din0 = rand128();
    iv0 = 1'b1;
    #1;
    while (got < 8 && cyc < 200) begin
      automatic bit acc = iv0 && ir0;
      automatic bit cons = ov0 && ordy0;
      if (cons) begin
        checks++;
        if (q.size() == 0 || int'(cnt0) != popc(q[0])) begin
          errors++; $display("FAIL stream_cnt got %0d at result %0d", cnt0, got);
        end
        if (q.size() != 0) void'(q.pop_front());
        if (last >= 0) begin
          checks++;
          if (cyc - last != 5) begin
            errors++; $display("FAIL stream_gap got %0d want 5", cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (acc) q.push_back(din0);
      step();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) din0 = rand128();
        else iv0 = 1'b0;
      end
    end
    iv0 = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL stream_results got %0d want 8", got); end
    step();
  endtask

  task automatic test_abort();
    int lat, bn;
    logic [7:0] c;
    logic [127:0] w;
    bit seen;
    ordy0 = 1'b1;
    din0 = rand128();
    iv0 = 1'b1;
    #1;
    step();
    iv0 = 1'b0;
    step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    #1;
    checks++;
    if (ir0 !== 1'b1 || busy0 !== 1'b0 || ov0 !== 1'b0) begin
      errors++; $display("FAIL abort_count ir=%b busy=%b ov=%b want 1 0 0", ir0, busy0, ov0);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ov0) seen = 1'b1;
      step();
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_result got ov=1 want 0"); end
    w = rand128();
    send_and_measure(1'b0, w, lat, bn, c);
    checks++;
    if (int'(c) != popc(w) || lat != 4) begin
      errors++; $display("FAIL abort_next cnt=%0d lat=%0d want cnt=%0d lat=4", c, lat, popc(w));
    end
    step();
    // abort in IDLE blocks a same-edge accept
    abort0 = 1'b1;
    iv0 = 1'b1;
    din0 = rand128();
    #1;
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL abort_idle_ir got %b want 0", ir0); end
    step();
    abort0 = 1'b0;
    iv0 = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b want 0", busy0); end
    // abort in DONE discards the pending result
    ordy0 = 1'b0;
    send_and_measure(1'b0, rand128(), lat, bn, c);
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
      errors++; $display("FAIL abort_done ov=%b ir=%b want ov=0 ir=1", ov0, ir0);
    end
    ordy0 = 1'b1;
  endtask

  task automatic test_async_reset();
    int lat, bn;
    logic [7:0] c;
    logic [127:0] w;
    ordy0 = 1'b0;
    din0 = {128{1'b1}};
    iv0 = 1'b1;
    #1;
    step();
    iv0 = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov0 !== 1'b0 || busy0 !== 1'b0 || ir0 !== 1'b0 || cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL arst_count ov=%b busy=%b ir=%b cnt=%0d want all 0", ov0, busy0, ir0, cnt0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (ir0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL arst_release ir=%b busy=%b want ir=1 busy=0", ir0, busy0);
    end
    send_and_measure(1'b0, {128{1'b1}}, lat, bn, c);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov0 !== 1'b0 || cnt0 !== 8'd0) begin
      errors++; $display("FAIL arst_done ov=%b cnt=%0d want ov=0 cnt=0", ov0, cnt0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    ordy0 = 1'b1;
    w = rand128();
    send_and_measure(1'b0, w, lat, bn, c);
    checks++;
    if (int'(c) != popc(w) || lat != 4) begin
      errors++; $display("FAIL arst_resume cnt=%0d lat=%0d want cnt=%0d lat=4", c, lat, popc(w));
    end
    step();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_patterns();
    test_early_exit();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
